hpdcache_req_arbiter: RTL and testbench

Shares the single HPDcache core request port between `NReq` requesters, for example load unit, store unit, AMO unit and PTW, using locked round-robin arbitration. It caps outstanding transactions per requester and routes responses back by source ID. It sits between the CVA6 load/store/PTW logic and the HPDcache when the cache is configured with fewer request ports than requesters.

---
 rtl/hpdcache_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_hpdcache_req_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_req_arbiter.sv
// Locked round-robin arbiter sharing one HPDcache request port between NReq requesters,
// with per-requester outstanding-request caps and response routing by source ID.
module hpdcache_req_arbiter #(
  parameter int NReq           = 4,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int TidWidth       = 3,
  parameter int MaxOutstanding = 4,
  localparam int SidWidth      = (NReq > 1) ? $clog2(NReq) : 1,
  localparam int CntWidth      = $clog2(MaxOutstanding + 1),
  localparam int BeWidth       = DataWidth / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NReq-1:0]             req_valid_i,
  output logic [NReq-1:0]             req_ready_o,
  input  logic [NReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NReq-1:0]             req_we_i,
  input  logic [NReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NReq*BeWidth-1:0]     req_be_i,
  input  logic [NReq*TidWidth-1:0]    req_tid_i,
  output logic                        cache_valid_o,
  input  logic                        cache_ready_i,
  output logic [AddrWidth-1:0]        cache_addr_o,
  output logic                        cache_we_o,
  output logic [DataWidth-1:0]        cache_wdata_o,
  output logic [BeWidth-1:0]          cache_be_o,
  output logic [TidWidth-1:0]         cache_tid_o,
  output logic [SidWidth-1:0]         cache_sid_o,
  input  logic                        rsp_valid_i,
  input  logic [SidWidth-1:0]         rsp_sid_i,
  input  logic [TidWidth-1:0]         rsp_tid_i,
  input  logic [DataWidth-1:0]        rsp_rdata_i,
  output logic [NReq-1:0]             rsp_valid_o,
  output logic [TidWidth-1:0]         rsp_tid_o,
  output logic [DataWidth-1:0]        rsp_rdata_o,
  output logic                        err_o
);

  // Handshake rule for every port pair here: a transfer happens in a cycle where
  // valid && ready; the offering side holds valid and payload stable until then.

  logic [SidWidth-1:0] r_rr_ptr;
  logic [SidWidth-1:0] r_lock_idx;
  logic                r_lock;
  logic                r_err;
  logic [CntWidth-1:0] r_cnt [NReq];

  logic [NReq-1:0]     w_eligible;
  logic [NReq-1:0]     w_rsp_hit;
  logic [NReq-1:0]     w_cnt_inc;
  logic                w_gnt_valid;
  logic [SidWidth-1:0] w_gnt_idx;
  logic [SidWidth-1:0] w_ptr_next;
  logic                w_lock_drop;
  logic                w_hs;
  logic                w_rsp_err;

  always_comb begin
    for (int i = 0; i < NReq; i++) begin
      w_eligible[i] = req_valid_i[i] && (r_cnt[i] < CntWidth'(MaxOutstanding));
    end
  end

  // Scan downward so the last hit written is the nearest eligible index at/after rr_ptr.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_lock_drop = 1'b0;
    if (r_lock) begin
      if (req_valid_i[r_lock_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = r_lock_idx;
      end else begin
        w_lock_drop = 1'b1;
      end
    end else begin
      for (int k = NReq - 1; k >= 0; k--) begin
        if (w_eligible[(int'(r_rr_ptr) + k) % NReq]) begin
          w_gnt_valid = 1'b1;
          w_gnt_idx   = SidWidth'((int'(r_rr_ptr) + k) % NReq);
        end
      end
    end
  end

  assign w_hs       = w_gnt_valid && cache_ready_i;
  assign w_ptr_next = (w_gnt_idx == SidWidth'(NReq - 1)) ? '0 : w_gnt_idx + SidWidth'(1);

  always_comb begin
    req_ready_o   = '0;
    w_cnt_inc     = '0;
    cache_addr_o  = '0;
    cache_we_o    = 1'b0;
    cache_wdata_o = '0;
    cache_be_o    = '0;
    cache_tid_o   = '0;
    for (int i = 0; i < NReq; i++) begin
      if (w_gnt_valid && (w_gnt_idx == SidWidth'(i))) begin
        req_ready_o[i] = cache_ready_i;
        w_cnt_inc[i]   = cache_ready_i;
        cache_addr_o   = req_addr_i[i*AddrWidth +: AddrWidth];
        cache_we_o     = req_we_i[i];
        cache_wdata_o  = req_wdata_i[i*DataWidth +: DataWidth];
        cache_be_o     = req_be_i[i*BeWidth +: BeWidth];
        cache_tid_o    = req_tid_i[i*TidWidth +: TidWidth];
      end
    end
  end

  assign cache_valid_o = w_gnt_valid;
  assign cache_sid_o   = w_gnt_idx;

  // A response only counts if it targets a real requester with something outstanding;
  // anything else (including out-of-range IDs) matches no bit and is flagged.
  always_comb begin
    for (int i = 0; i < NReq; i++) begin
      w_rsp_hit[i] = rsp_valid_i && (rsp_sid_i == SidWidth'(i)) && (r_cnt[i] != '0);
    end
  end

  assign w_rsp_err   = rsp_valid_i && (w_rsp_hit == '0);
  assign rsp_valid_o = w_rsp_hit;
  assign rsp_tid_o   = rsp_tid_i;
  assign rsp_rdata_o = rsp_rdata_i;
  assign err_o       = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < NReq; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if (w_hs) begin
        r_rr_ptr <= w_ptr_next;
        r_lock   <= 1'b0;
      end else if (w_gnt_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_gnt_idx;
      end else if (w_lock_drop) begin
        r_lock <= 1'b0;
      end
      if (w_lock_drop || w_rsp_err) begin
        r_err <= 1'b1;
      end
      for (int i = 0; i < NReq; i++) begin
        if (w_cnt_inc[i] && !w_rsp_hit[i]) begin
          r_cnt[i] <= r_cnt[i] + CntWidth'(1);
        end else if (w_rsp_hit[i] && !w_cnt_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_req_arbiter.sv
// Bench for hpdcache_req_arbiter: directed vector table, a mid-transaction reset
// sequence, and randomized traffic against a rule-level reference model.
module tb_hpdcache_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 3;
  localparam int MO = 4;
  localparam int SW = 2;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_we;
  logic [N*DW-1:0]   req_wdata;
  logic [N*BW-1:0]   req_be;
  logic [N*TW-1:0]   req_tid;
  logic              cache_valid;
  logic              cache_ready;
  logic [AW-1:0]     cache_addr;
  logic              cache_we;
  logic [DW-1:0]     cache_wdata;
  logic [BW-1:0]     cache_be;
  logic [TW-1:0]     cache_tid;
  logic [SW-1:0]     cache_sid;
  logic              rsp_valid;
  logic [SW-1:0]     rsp_sid;
  logic [TW-1:0]     rsp_tid;
  logic [DW-1:0]     rsp_rdata;
  logic [N-1:0]      rsp_valid_out;
  logic [TW-1:0]     rsp_tid_out;
  logic [DW-1:0]     rsp_rdata_out;
  logic              err;

  hpdcache_req_arbiter #(
    .NReq(N), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_be_i(req_be), .req_tid_i(req_tid),
    .cache_valid_o(cache_valid), .cache_ready_i(cache_ready), .cache_addr_o(cache_addr),
    .cache_we_o(cache_we), .cache_wdata_o(cache_wdata), .cache_be_o(cache_be),
    .cache_tid_o(cache_tid), .cache_sid_o(cache_sid),
    .rsp_valid_i(rsp_valid), .rsp_sid_i(rsp_sid), .rsp_tid_i(rsp_tid), .rsp_rdata_i(rsp_rdata),
    .rsp_valid_o(rsp_valid_out), .rsp_tid_o(rsp_tid_out), .rsp_rdata_o(rsp_rdata_out),
    .err_o(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = '0;
    cache_ready = 1'b0;
    rsp_valid   = 1'b0;
    rsp_sid     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // driver state: bench-side copy of every requester's payload
  logic [AW-1:0] p_addr  [N];
  logic          p_we    [N];
  logic [DW-1:0] p_wdata [N];
  logic [BW-1:0] p_be    [N];
  logic [TW-1:0] p_tid   [N];

  task automatic set_payload(input int i, input logic [AW-1:0] a, input logic we,
                             input logic [DW-1:0] d, input logic [BW-1:0] be, input logic [TW-1:0] t);
    p_addr[i] = a; p_we[i] = we; p_wdata[i] = d; p_be[i] = be; p_tid[i] = t;
    req_addr[i*AW +: AW]  = a;
    req_we[i]             = we;
    req_wdata[i*DW +: DW] = d;
    req_be[i*BW +: BW]    = be;
    req_tid[i*TW +: TW]   = t;
  endtask

  function automatic logic [AW-1:0] base_addr(input int i);
    return 64'h8000_0000 + 64'(i) * 64'h100;
  endfunction

  task automatic fixed_payloads();
    for (int i = 0; i < N; i++)
      set_payload(i, base_addr(i), i[0], 64'hD0D0_0000 + 64'(i), 8'(1 << i), 3'(i + 1));
  endtask

  // vector table
  typedef struct {
    bit          rst_first;
    logic [3:0]  valid;
    bit          rdy;
    bit          rv;
    logic [1:0]  rs;
    logic [3:0]  e_ready;
    bit          e_cv;
    logic [1:0]  e_sid;
    logic [3:0]  e_rv;
    bit          e_err;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit r, logic [3:0] v, bit rdy, bit rv, logic [1:0] rs,
                              logic [3:0] er, bit ecv, logic [1:0] es, logic [3:0] erv, bit ee);
    vec_t x;
    x.rst_first = r; x.valid = v; x.rdy = rdy; x.rv = rv; x.rs = rs;
    x.e_ready = er; x.e_cv = ecv; x.e_sid = es; x.e_rv = erv; x.e_err = ee;
    vt.push_back(x);
  endfunction

  task automatic check_grant(input string tag, input bit ecv, input logic [1:0] es);
    int g;
    g = int'(es);
    check({tag, "_cvalid"}, 128'(cache_valid), 128'(ecv));
    check({tag, "_sid"},    128'(cache_sid),   ecv ? 128'(es) : 128'(0));
    check({tag, "_addr"},   128'(cache_addr),  ecv ? 128'(p_addr[g]) : 128'(0));
    check({tag, "_tid"},    128'(cache_tid),   ecv ? 128'(p_tid[g]) : 128'(0));
    check({tag, "_wdata"},  128'({cache_we, cache_be, cache_wdata}),
          ecv ? 128'({p_we[g], p_be[g], p_wdata[g]}) : 128'(0));
  endtask

  task automatic run_row(input vec_t v, input int n);
    string tag;
    if (v.rst_first) do_reset();
    tag         = $sformatf("row%0d", n);
    req_valid   = v.valid;
    cache_ready = v.rdy;
    rsp_valid   = v.rv;
    rsp_sid     = v.rs;
    rsp_tid     = 3'(n);
    rsp_rdata   = 64'hCAFE_0000_0000_0000 + 64'(n);
    #2;
    check({tag, "_ready"}, 128'(req_ready), 128'(v.e_ready));
    check_grant(tag, v.e_cv, v.e_sid);
    check({tag, "_rsp_valid"}, 128'(rsp_valid_out), 128'(v.e_rv));
    check({tag, "_rsp_bcast"}, 128'({rsp_tid_out, rsp_rdata_out}), 128'({3'(n), 64'hCAFE_0000_0000_0000 + 64'(n)}));
    check({tag, "_err"}, 128'(err), 128'(v.e_err));
    @(posedge clk);
    #1;
  endtask

  // reference model state (rule level: pointer, lock, outstanding counts, error)
  int m_ptr;
  bit m_lock;
  int m_lidx;
  int m_cnt [N];
  bit m_err;

  function automatic void model_reset();
    m_ptr = 0; m_lock = 0; m_lidx = 0; m_err = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  // Winner = eligible requester with the smallest clockwise distance from the pointer.
  function automatic int model_grant(input logic [N-1:0] v);
    int best, bestd, d;
    if (m_lock) return v[m_lidx] ? m_lidx : -1;
    best = -1; bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - m_ptr + N) % N;
      if (v[i] && m_cnt[i] < MO && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  // scoreboard: expected {cache_valid, sid, tid, addr} per cycle
  logic [AW+TW+SW:0] exp_q[$];

  initial begin
    int g, nlist, pick, accepted;
    int list [N];
    logic [N-1:0] exp_rv;
    logic [AW+TW+SW:0] exp_pkt;

    req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0; req_be = '0; req_tid = '0;
    cache_ready = 1'b0; rsp_valid = 1'b0; rsp_sid = '0; rsp_tid = '0; rsp_rdata = '0;
    fixed_payloads();

    // rotation with all requesters valid and the cache always ready
    add(1, 4'b1111, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 0);
    // lock on 2 while the cache stalls, 0 arrives meanwhile
    add(1, 4'b0100, 0, 0, 0, 4'b0000, 1, 2, 4'b0000, 0);
    add(0, 4'b0101, 0, 0, 0, 4'b0000, 1, 2, 4'b0000, 0);
    add(0, 4'b0101, 0, 0, 0, 4'b0000, 1, 2, 4'b0000, 0);
    add(0, 4'b0101, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 0);
    add(0, 4'b0001, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 0);
    // outstanding cap on requester 1
    add(1, 4'b0010, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);
    add(0, 4'b0010, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);
    add(0, 4'b0010, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);
    add(0, 4'b0010, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);
    add(0, 4'b0010, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b0010, 1, 1, 1, 4'b0000, 0, 0, 4'b0010, 0);
    add(0, 4'b0010, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);
    // same-cycle handshake + response on 3 at count 2, then drain to empty
    add(1, 4'b1000, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 0);
    add(0, 4'b1000, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 0);
    add(0, 4'b1000, 1, 1, 3, 4'b1000, 1, 3, 4'b1000, 0);
    add(0, 4'b0000, 0, 1, 3, 4'b0000, 0, 0, 4'b1000, 0);
    add(0, 4'b0000, 0, 1, 3, 4'b0000, 0, 0, 4'b1000, 0);
    add(0, 4'b0000, 0, 1, 3, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 1);
    // stray response to an idle requester, error stays sticky
    add(1, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b0001, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 1);
    // locked requester drops valid
    add(1, 4'b0010, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b0100, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 1);

    foreach (vt[n]) run_row(vt[n], n);

    // reset mid-transaction: 3 outstanding on 0, lock held on 1
    do_reset();
    req_valid = 4'b0001; cache_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    req_valid = 4'b0010; cache_ready = 1'b0;
    #2;
    check_grant("mid_lock", 1'b1, 2'd1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 4'b0000; rsp_valid = 1'b1; rsp_sid = 2'd0;
    #1;
    check("mid_rst_cvalid", 128'(cache_valid), 128'(0));
    check("mid_rst_ready",  128'(req_ready),   128'(0));
    check("mid_rst_rsp",    128'(rsp_valid_out), 128'(0));
    check("mid_rst_err",    128'(err),         128'(0));
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 4'b0011; cache_ready = 1'b1; rsp_valid = 1'b1; rsp_sid = 2'd0;
    #2;
    check_grant("post_rst", 1'b1, 2'd0);
    check("post_rst_ready", 128'(req_ready), 128'(4'b0001));
    check("post_rst_rsp",   128'(rsp_valid_out), 128'(0));
    @(posedge clk); #1;
    rsp_valid = 1'b0; req_valid = 4'b0000;
    #2;
    check("post_rst_err", 128'(err), 128'(1));
    @(posedge clk); #1;

    // randomized legal traffic against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_payload(i, {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom},
                      8'($urandom), 3'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      cache_ready = ($urandom_range(0, 3) != 0);
      nlist = 0;
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) begin list[nlist] = i; nlist++; end
      rsp_valid = (nlist > 0) && ($urandom_range(0, 1) == 1);
      pick      = (nlist > 0) ? list[$urandom_range(0, nlist - 1)] : 0;
      rsp_sid   = 2'(pick);
      rsp_tid   = 3'($urandom);
      rsp_rdata = {$urandom, $urandom};

      g = model_grant(req_valid);
      exp_rv = '0;
      if (rsp_valid && m_cnt[pick] > 0) exp_rv[pick] = 1'b1;
      exp_q.push_back((g >= 0) ? {1'b1, 2'(g), p_tid[g], p_addr[g]} : '0);
      #2;
      exp_pkt = exp_q.pop_front();
      check($sformatf("rnd%0d_grant", cyc), 128'({cache_valid, cache_sid, cache_tid, cache_addr}), 128'(exp_pkt));
      check($sformatf("rnd%0d_ready", cyc), 128'(req_ready),
            (g >= 0 && cache_ready) ? 128'(1 << g) : 128'(0));
      check($sformatf("rnd%0d_rsp", cyc), 128'({rsp_valid_out, rsp_tid_out, rsp_rdata_out}),
            128'({exp_rv, rsp_tid, rsp_rdata}));
      check($sformatf("rnd%0d_err", cyc), 128'(err), 128'(m_err));

      accepted = -1;
      if (m_lock && !req_valid[m_lidx]) begin
        m_err = 1; m_lock = 0;
      end else if (g >= 0) begin
        if (cache_ready) begin
          accepted = g; m_cnt[g]++; m_ptr = (g + 1) % N; m_lock = 0;
        end else begin
          m_lock = 1; m_lidx = g;
        end
      end
      if (rsp_valid) begin
        if (m_cnt[pick] > 0) m_cnt[pick]--;
        else m_err = 1;
      end
      @(posedge clk); #1;
      if (accepted >= 0) req_valid[accepted] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
